// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the data-memory responder and its lane-alignment helper.
package dmem_responder_pkg;

  localparam logic [1:0] MEM_W_B = 2'b00;
  localparam logic [1:0] MEM_W_H = 2'b01;
  localparam logic [1:0] MEM_W_W = 2'b10;
  localparam logic [1:0] MEM_W_D = 2'b11;

  localparam int DMEM_WAIT_MAX = 15;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for a 64-bit little-endian word: byte enables,
// store shift, load extract/extend and misalignment detection.
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [1:0]  width_i,
  input  logic [2:0]  offset_i,
  input  logic        sign_i,
  input  logic [63:0] store_data_i,
  input  logic [63:0] load_word_i,
  output logic [7:0]  byte_en_o,
  output logic [63:0] store_data_o,
  output logic [63:0] load_data_o,
  output logic        misaligned_o
);

  logic [5:0]  shamt;
  logic [63:0] lane;

  assign shamt        = {offset_i, 3'b000};
  assign store_data_o = store_data_i << shamt;
  assign lane         = load_word_i >> shamt;

  always_comb begin
    byte_en_o    = 8'h00;
    load_data_o  = lane;
    misaligned_o = 1'b0;
    case (width_i)
      MEM_W_B: begin
        byte_en_o   = 8'h01 << offset_i;
        load_data_o = {{56{sign_i & lane[7]}}, lane[7:0]};
      end
      MEM_W_H: begin
        byte_en_o    = 8'h03 << offset_i;
        load_data_o  = {{48{sign_i & lane[15]}}, lane[15:0]};
        misaligned_o = offset_i[0];
      end
      MEM_W_W: begin
        byte_en_o    = 8'h0F << offset_i;
        load_data_o  = {{32{sign_i & lane[31]}}, lane[31:0]};
        misaligned_o = |offset_i[1:0];
      end
      default: begin
        byte_en_o    = 8'hFF;
        load_data_o  = lane;
        misaligned_o = |offset_i;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Mem-stage data-memory responder: synchronous 64-bit store with programmable
// wait states, stall request, fault pulse and flush abort.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 64,
  parameter int DEPTH_LOG2  = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Mem_DcacheEN,
  input  logic                  Mem_DcacheRd,
  input  logic [1:0]            Mem_DcacheWidth,
  input  logic                  Mem_DcacheSign,
  input  logic [ADDR_WIDTH-1:0] Mem_DcacheAddr,
  input  logic [DATA_WIDTH-1:0] EXMem_Rs2Data,
  input  logic                  Csr_Memflush,
  output logic [DATA_WIDTH-1:0] Dcache_DataRd,
  output logic                  Dcache_StallReq,
  output logic                  Dcache_Fault
);

  localparam int RangeLsb = DEPTH_LOG2 + 3;
  localparam int WaitClamped = (WAIT_CYCLES > DMEM_WAIT_MAX) ? DMEM_WAIT_MAX : WAIT_CYCLES;
  localparam logic [3:0] WaitInit = 4'((WaitClamped > 0) ? WaitClamped - 1 : 0);

  dmem_state_e state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  rd_q, sign_q, fault_q;
  logic [1:0]            width_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, data_q, rdword_q;

  logic                  in_idle, accept, enter_resp, fault_s, misaligned;
  logic                  rd_s, sign_s;
  logic [1:0]            width_s;
  logic [ADDR_WIDTH-1:0] addr_s;
  logic [DATA_WIDTH-1:0] wdata_s, wdata_shift, load_ext;
  logic [7:0]            byte_en;
  logic [DEPTH_LOG2-1:0] idx_s;

  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

  // With zero wait states the write happens on the accept edge, so IDLE uses the live request.
  assign in_idle = (state_q == DMEM_IDLE);
  assign rd_s    = in_idle ? Mem_DcacheRd    : rd_q;
  assign width_s = in_idle ? Mem_DcacheWidth : width_q;
  assign sign_s  = in_idle ? Mem_DcacheSign  : sign_q;
  assign addr_s  = in_idle ? Mem_DcacheAddr  : addr_q;
  assign wdata_s = in_idle ? EXMem_Rs2Data   : wdata_q;
  assign idx_s   = addr_s[RangeLsb-1:3];
  assign fault_s = misaligned | (|addr_s[ADDR_WIDTH-1:RangeLsb]);
  assign accept  = in_idle & Mem_DcacheEN & ~Csr_Memflush;

  dmem_lane_align u_align (
    .width_i     (width_s),
    .offset_i    (addr_s[2:0]),
    .sign_i      (sign_s),
    .store_data_i(wdata_s),
    .load_word_i (rdword_q),
    .byte_en_o   (byte_en),
    .store_data_o(wdata_shift),
    .load_data_o (load_ext),
    .misaligned_o(misaligned)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DMEM_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      DMEM_IDLE: begin
        if (accept) begin
          if (WaitClamped > 0) begin
            state_d = DMEM_WAIT;
            cnt_d   = WaitInit;
          end else begin
            state_d = DMEM_RESP;
          end
        end
      end
      DMEM_WAIT: begin
        if (Csr_Memflush) begin
          state_d = DMEM_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = DMEM_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = DMEM_IDLE;
    endcase
  end

  assign enter_resp = (state_d == DMEM_RESP) && (state_q != DMEM_RESP);

  always_comb begin
    Dcache_StallReq = 1'b0;
    Dcache_DataRd   = data_q;
    Dcache_Fault    = fault_q;
    case (state_q)
      DMEM_IDLE: Dcache_StallReq = Mem_DcacheEN;
      DMEM_WAIT: Dcache_StallReq = ~Csr_Memflush;
      DMEM_RESP: Dcache_DataRd   = fault_q ? '0 : load_ext;
      default:   Dcache_StallReq = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q    <= 1'b0;
      width_q <= 2'b00;
      sign_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      if (accept) begin
        rd_q    <= Mem_DcacheRd;
        width_q <= Mem_DcacheWidth;
        sign_q  <= Mem_DcacheSign;
        addr_q  <= Mem_DcacheAddr;
        wdata_q <= EXMem_Rs2Data;
      end
      if (state_q == DMEM_RESP) data_q <= Dcache_DataRd;
      fault_q <= enter_resp & fault_s;
    end
  end

  // Memory contents deliberately have no reset.
  always_ff @(posedge clk) begin
    if (enter_resp) begin
      rdword_q <= mem[idx_s];
      if (!rd_s && !fault_s) begin
        for (int b = 0; b < 8; b++) begin
          if (byte_en[b]) mem[idx_s][b*8 +: 8] <= wdata_shift[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with 2, 0 and 4 wait states.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  logic        clock = 1'b0;
  logic [2:0]  rst = 3'b111;
  logic [2:0]  en = 3'b000;
  logic        rd = 1'b0, sgn = 1'b0, flush = 1'b0;
  logic [1:0]  width = 2'b00;
  logic [31:0] addr = 32'h0;
  logic [63:0] wdata = 64'h0;
  logic [2:0]  stall, fault;
  logic [63:0] dataA, dataB, dataC;

  int checkCount = 0;
  int failCount = 0;

  always #5 clock = ~clock;

  dmem_responder #(.WAIT_CYCLES(2)) dutA (
    .clk(clock), .rst(rst[0]), .Mem_DcacheEN(en[0]), .Mem_DcacheRd(rd),
    .Mem_DcacheWidth(width), .Mem_DcacheSign(sgn), .Mem_DcacheAddr(addr),
    .EXMem_Rs2Data(wdata), .Csr_Memflush(flush), .Dcache_DataRd(dataA),
    .Dcache_StallReq(stall[0]), .Dcache_Fault(fault[0]));

  dmem_responder #(.WAIT_CYCLES(0)) dutB (
    .clk(clock), .rst(rst[1]), .Mem_DcacheEN(en[1]), .Mem_DcacheRd(rd),
    .Mem_DcacheWidth(width), .Mem_DcacheSign(sgn), .Mem_DcacheAddr(addr),
    .EXMem_Rs2Data(wdata), .Csr_Memflush(flush), .Dcache_DataRd(dataB),
    .Dcache_StallReq(stall[1]), .Dcache_Fault(fault[1]));

  dmem_responder #(.WAIT_CYCLES(4)) dutC (
    .clk(clock), .rst(rst[2]), .Mem_DcacheEN(en[2]), .Mem_DcacheRd(rd),
    .Mem_DcacheWidth(width), .Mem_DcacheSign(sgn), .Mem_DcacheAddr(addr),
    .EXMem_Rs2Data(wdata), .Csr_Memflush(flush), .Dcache_DataRd(dataC),
    .Dcache_StallReq(stall[2]), .Dcache_Fault(fault[2]));

  function automatic logic [63:0] dataOf(input int sel);
    case (sel)
      0:       return dataA;
      1:       return dataB;
      default: return dataC;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%h expected 0x%h", tag, actual, expected);
    end
  endtask

  // One complete access on instance sel: counts stall cycles, captures RESP data/fault,
  // then samples the outputs one cycle after RESP.
  task automatic applyStimulus(input int sel, input logic isRd, input logic [1:0] w,
                               input logic s, input logic [31:0] a, input logic [63:0] d,
                               output logic [63:0] rdata, output logic flt, output int stalls,
                               output logic [63:0] holdData, output logic holdFault);
    bit done = 0;
    @(posedge clock); #1;
    rd = isRd; width = w; sgn = s; addr = a; wdata = d; en[sel] = 1'b1;
    stalls = 0; rdata = '0; flt = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clock);
      if (stall[sel]) stalls++;
      else begin
        rdata = dataOf(sel);
        flt   = fault[sel];
        done  = 1;
      end
    end
    if (!done) checkOutput("timeout", 64'd0, 64'd1);
    @(posedge clock); #1;
    en[sel] = 1'b0;
    @(negedge clock);
    holdData  = dataOf(sel);
    holdFault = fault[sel];
  endtask

  logic [63:0] d, h;
  logic        f, hf;
  int          s;

  initial begin
    repeat (3) @(posedge clock);
    #1 rst = 3'b000;
    @(negedge clock);
    checkOutput("reset.stall", {61'd0, stall}, 64'd0);
    checkOutput("reset.fault", {61'd0, fault}, 64'd0);
    checkOutput("reset.data",  dataA | dataB | dataC, 64'd0);

    applyStimulus(0, 0, MEM_W_W, 0, 32'h100, 64'hDEADBEEF, d, f, s, h, hf);
    checkOutput("stW.stalls", 64'(s), 64'd3);
    checkOutput("stW.fault", {63'd0, f}, 64'd0);
    applyStimulus(0, 1, MEM_W_W, 0, 32'h100, 64'h0, d, f, s, h, hf);
    checkOutput("ldW.data", d, 64'h00000000_DEADBEEF);
    checkOutput("ldW.stalls", 64'(s), 64'd3);
    checkOutput("ldW.hold", h, 64'h00000000_DEADBEEF);

    applyStimulus(0, 0, MEM_W_B, 0, 32'h103, 64'h80, d, f, s, h, hf);
    applyStimulus(0, 1, MEM_W_B, 1, 32'h103, 64'h0, d, f, s, h, hf);
    checkOutput("ldB.sext", d, 64'hFFFFFFFF_FFFFFF80);
    applyStimulus(0, 1, MEM_W_B, 0, 32'h103, 64'h0, d, f, s, h, hf);
    checkOutput("ldB.zext", d, 64'h80);
    applyStimulus(0, 1, MEM_W_W, 0, 32'h100, 64'h0, d, f, s, h, hf);
    checkOutput("ldW.lanes", d, 64'h00000000_80ADBEEF);

    applyStimulus(0, 0, MEM_W_D, 0, 32'h208, 64'h01234567_89ABCDEF, d, f, s, h, hf);
    applyStimulus(0, 1, MEM_W_H, 0, 32'h20A, 64'h0, d, f, s, h, hf);
    checkOutput("ldH.zext", d, 64'h89AB);
    applyStimulus(0, 1, MEM_W_H, 1, 32'h20A, 64'h0, d, f, s, h, hf);
    checkOutput("ldH.sext", d, 64'hFFFFFFFF_FFFF89AB);
    applyStimulus(0, 1, MEM_W_W, 1, 32'h20C, 64'h0, d, f, s, h, hf);
    checkOutput("ldW.hi", d, 64'h01234567);
    applyStimulus(0, 1, MEM_W_D, 1, 32'h208, 64'h0, d, f, s, h, hf);
    checkOutput("ldD", d, 64'h01234567_89ABCDEF);

    applyStimulus(0, 1, MEM_W_W, 0, 32'h102, 64'h0, d, f, s, h, hf);
    checkOutput("misW.fault", {63'd0, f}, 64'd1);
    checkOutput("misW.data", d, 64'd0);
    checkOutput("misW.pulse", {63'd0, hf}, 64'd0);
    applyStimulus(0, 0, MEM_W_W, 0, 32'h102, 64'h12345678, d, f, s, h, hf);
    checkOutput("misStW.fault", {63'd0, f}, 64'd1);
    applyStimulus(0, 0, MEM_W_H, 0, 32'h101, 64'h5555, d, f, s, h, hf);
    checkOutput("misStH.fault", {63'd0, f}, 64'd1);
    applyStimulus(0, 1, MEM_W_W, 0, 32'h100, 64'h0, d, f, s, h, hf);
    checkOutput("misSt.noWrite", d, 64'h00000000_80ADBEEF);
    applyStimulus(0, 1, MEM_W_D, 0, 32'h8000, 64'h0, d, f, s, h, hf);
    checkOutput("range.fault", {63'd0, f}, 64'd1);
    checkOutput("range.data", d, 64'd0);
    applyStimulus(0, 1, MEM_W_D, 0, 32'h7FF8, 64'h0, d, f, s, h, hf);
    checkOutput("rangeEdge.fault", {63'd0, f}, 64'd0);

    applyStimulus(0, 0, MEM_W_D, 0, 32'h300, 64'h1111, d, f, s, h, hf);
    @(posedge clock); #1;
    rd = 0; width = MEM_W_D; addr = 32'h300; wdata = 64'h2222; en[0] = 1'b1;
    @(negedge clock);
    checkOutput("flush.req", {63'd0, stall[0]}, 64'd1);
    @(posedge clock); #1 flush = 1'b1;
    @(negedge clock);
    checkOutput("flush.stallDrop", {63'd0, stall[0]}, 64'd0);
    @(posedge clock); #1 flush = 1'b0; en[0] = 1'b0;
    @(negedge clock);
    checkOutput("flush.idle", {63'd0, stall[0]}, 64'd0);
    checkOutput("flush.fault", {63'd0, fault[0]}, 64'd0);
    applyStimulus(0, 1, MEM_W_D, 0, 32'h300, 64'h0, d, f, s, h, hf);
    checkOutput("flush.noWrite", d, 64'h1111);

    @(posedge clock); #1;
    rd = 0; width = MEM_W_D; addr = 32'h300; wdata = 64'h3333; en[0] = 1'b1; flush = 1'b1;
    @(posedge clock); #1 en[0] = 1'b0; flush = 1'b0;
    @(negedge clock);
    checkOutput("flushIdle.noAccept", {63'd0, stall[0]}, 64'd0);
    applyStimulus(0, 1, MEM_W_D, 0, 32'h300, 64'h0, d, f, s, h, hf);
    checkOutput("flushIdle.noWrite", d, 64'h1111);

    applyStimulus(1, 0, MEM_W_D, 0, 32'h10, 64'h55, d, f, s, h, hf);
    checkOutput("w0.stStalls", 64'(s), 64'd1);
    applyStimulus(1, 1, MEM_W_D, 0, 32'h10, 64'h0, d, f, s, h, hf);
    checkOutput("w0.ldStalls", 64'(s), 64'd1);
    checkOutput("w0.data", d, 64'h55);

    applyStimulus(2, 0, MEM_W_D, 0, 32'h40, 64'hAAAA, d, f, s, h, hf);
    checkOutput("w4.stalls", 64'(s), 64'd5);
    applyStimulus(2, 1, MEM_W_D, 0, 32'h40, 64'h0, d, f, s, h, hf);
    checkOutput("w4.data", d, 64'hAAAA);
    @(posedge clock); #1;
    rd = 0; width = MEM_W_D; addr = 32'h40; wdata = 64'h5555; en[2] = 1'b1;
    @(posedge clock);
    @(posedge clock); #1;
    rst[2] = 1'b1; en[2] = 1'b0;
    #1;
    checkOutput("rstWait.stall", {63'd0, stall[2]}, 64'd0);
    checkOutput("rstWait.fault", {63'd0, fault[2]}, 64'd0);
    checkOutput("rstWait.data", dataC, 64'd0);
    @(posedge clock); #1 rst[2] = 1'b0;
    applyStimulus(2, 1, MEM_W_D, 0, 32'h40, 64'h0, d, f, s, h, hf);
    checkOutput("rstWait.noWrite", d, 64'hAAAA);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's Mem-stage data-memory request interface.
- Receives the signals the Mem stage drives (enable, read/write, width, sign, address, store data) and returns load data.
- Asserts a stall request while an access is in progress; this replaces the constant-zero Dcache stall input to Ctrl.
- Holds a synchronous 64-bit-wide data store with a programmable number of wait states, so the pipeline's stall paths are exercised with real latency.

Parameters:
- ADDR_WIDTH, 32, byte address width; matches the core address width.
- DATA_WIDTH, 64, memory word and read-data width; matches the SIMD data width.
- DEPTH_LOG2, 12, log2 of the number of 64-bit words (default 4096 words, 32 KiB).
- WAIT_CYCLES, 2, wait states inserted before the response cycle (range 0..15).

Ports:
- clk  in  1  core clock.
- rst  in  1  reset, asynchronous, active-high.
- Mem_DcacheEN  in  1  access request, level; held by the pipeline while stalled.
- Mem_DcacheRd  in  1  1 = load, 0 = store.
- Mem_DcacheWidth  in  2  00 byte, 01 half, 10 word, 11 double.
- Mem_DcacheSign  in  1  1 = sign-extend load data, 0 = zero-extend.
- Mem_DcacheAddr  in  ADDR_WIDTH  byte address.
- EXMem_Rs2Data  in  DATA_WIDTH  store data, right-aligned.
- Csr_Memflush  in  1  abort the in-flight access.
- Dcache_DataRd  out  DATA_WIDTH  load data, valid in the RESP cycle.
- Dcache_StallReq  out  1  hold the pipeline.
- Dcache_Fault  out  1  one-cycle pulse in RESP for a misaligned or out-of-range access.

Behaviour:
- Single clock domain. Reset is asynchronous and active-high.
  - On reset: state = IDLE, wait counter = 0, all latched request fields = 0, Dcache_DataRd = 0, Dcache_StallReq = 0, Dcache_Fault = 0.
  - Memory contents are not reset.
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - Dcache_StallReq = Mem_DcacheEN, driven combinationally so the pipeline freezes in the request cycle.
  - On EN = 1 and Csr_Memflush = 0, latch Rd, Width, Sign, Addr and store data.
  - Next state is WAIT if WAIT_CYCLES > 0 (counter loaded with WAIT_CYCLES-1), otherwise RESP.
- WAIT:
  - Dcache_StallReq = 1.
  - The counter decrements each cycle; at 0, go to RESP.
  - New EN values are ignored because the pipeline is frozen.
- RESP:
  - Dcache_StallReq = 0 and Dcache_DataRd is valid, so the pipeline advances at the end of this cycle.
  - Next state is IDLE, unconditionally.
  - A new request is accepted only from IDLE, so back-to-back accesses cost WAIT_CYCLES+2 cycles each.
- Latency: from the EN rising edge to the RESP cycle is WAIT_CYCLES+1 clock edges.
- Store commit:
  - The memory write occurs on the clock edge that enters RESP, using byte enables derived from the latched width and Addr[2:0].
  - Store data is shifted left by 8*Addr[2:0].
  - No write occurs on a fault or an abort.
- Load data:
  - The word is read at the RESP-entry edge.
  - The selected lanes are extracted at Addr[2:0], then sign- or zero-extended to DATA_WIDTH according to Sign. A double access ignores Sign.
  - Dcache_DataRd holds its value after RESP until the next RESP, and is 0 on a fault.
- Fault conditions (fault has priority over the access):
  - Misaligned access: half with Addr[0] set, word with Addr[1:0] nonzero, double with Addr[2:0] nonzero.
  - Address at or beyond 2^(DEPTH_LOG2+3).
  - On a fault: Dcache_Fault = 1 in RESP only, no write, data = 0.
- Abort:
  - Csr_Memflush = 1 in IDLE blocks acceptance.
  - Csr_Memflush = 1 in WAIT forces IDLE next cycle with no write and no fault; Dcache_StallReq drops in that same flush cycle.
  - Csr_Memflush in RESP has no effect, since the write has already committed.
- Little-endian byte order. Address bits above the word index are ignored only after the range check.
- Simultaneous EN and rst: reset wins.
- Reset asserted mid-WAIT: the FSM returns to IDLE immediately and no write occurs.

Decomposition:
- Shared package / Define additions:
  - Width encodings MEM_W_B, MEM_W_H, MEM_W_W and MEM_W_D.
  - Responder state encodings.
  - DMEM_WAIT_MAX = 15.
- Sub-module dmem_lane_align (combinational), which contains:
  - byte-enable generation,
  - store-data shift,
  - load extract/extend,
  - misalignment detect.
  Reused by any future bus bridge.

Test Plan:
- WAIT_CYCLES=2: store word 0xDEADBEEF at 0x100, then load word with Sign=0 → stall high for 3 cycles per access, RESP data 0x00000000_DEADBEEF, no fault.
- Store byte 0x80 at 0x103, then load byte with Sign=1 → data 0xFFFFFFFF_FFFFFF80; with Sign=0 → 0x80; the other lanes of word 0x100 are unchanged.
- Store double 0x01234567_89ABCDEF at 0x208, then load half at 0x20A with Sign=0 → 0x89AB.
- Load word at 0x102 → Dcache_Fault pulses in RESP, data 0, memory unchanged; address 0x8000 with DEPTH_LOG2=12 → fault.
- Store at 0x300 with Csr_Memflush pulsed in the first WAIT cycle → StallReq drops that cycle, FSM returns to IDLE, a later load at 0x300 returns its prior contents.
- WAIT_CYCLES=0: a load completes with stall for exactly 1 cycle; rst asserted mid-WAIT with WAIT_CYCLES=4 → all outputs 0 immediately, no write.
